// File: rtl/esp_link_pkg.sv
// Shared constants and FSM encoding for the ESP storage command link.
package esp_link_pkg;
  localparam int CMD_W        = 28;
  localparam int TAG_LSB      = 0;
  localparam int TAG_MSB      = 7;
  localparam int RSP_FLAG_BIT = 27;

  localparam logic [CMD_W-1:0] ESP_INIT_WORD = 28'h8FF0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DELIVER  = 3'd4
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/esp_cmd_arbiter.sv
// Round-robin arbiter sharing the single ESP storage command channel.
// One command in flight at a time; each is tagged, matched on response or
// aborted by timeout, and the result is routed back to its requester.
module esp_cmd_arbiter
  import esp_link_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [CMD_W-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     link_ready,
  output logic [CMD_W-1:0]         issue_cmd,
  output logic                     issue_valid,
  input  logic [CMD_W-1:0]         link_rsp,
  input  logic                     link_rsp_vld,
  output logic                     busy,
  output logic [2:0]               debug_state
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int HI_W  = CMD_W - TAG_MSB - 1;

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, owner, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic              pick_any;
  logic [7:0]        tag;
  logic [HI_W-1:0]   cmd_hi;
  logic [CNT_W-1:0]  cnt;
  logic              match, timed_out;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign match     = link_rsp_vld & link_rsp[RSP_FLAG_BIT] &
                     (link_rsp[TAG_MSB:TAG_LSB] == tag);
  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Next state and Moore outputs; pulses are suppressed while frozen.
  always_comb begin
    state_nxt   = state;
    req_ack     = '0;
    rsp_valid   = '0;
    issue_valid = 1'b0;
    issue_cmd   = '0;
    busy        = (state != ST_IDLE);
    debug_state = state;
    case (state)
      ST_IDLE: if (enable && link_ready && |req_valid) state_nxt = ST_GRANT;
      ST_GRANT: begin
        // Requesters hold req_valid until ack; fall back to IDLE if one lied.
        if (enable) state_nxt = pick_any ? ST_ISSUE : ST_IDLE;
        if (enable) req_ack = pick_grant;
      end
      ST_ISSUE: begin
        issue_cmd = {cmd_hi, tag};
        if (enable) begin
          issue_valid = 1'b1;
          state_nxt   = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: if (enable && (match || timed_out)) state_nxt = ST_DELIVER;
      ST_DELIVER: begin
        if (enable) begin
          rsp_valid[owner] = 1'b1;
          state_nxt        = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      tag      <= '0;
      cmd_hi   <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (enable) begin
      state <= state_nxt;
      case (state)
        ST_GRANT: if (pick_any) begin
          owner  <= pick_idx;
          cmd_hi <= req_cmd[int'(pick_idx)*CMD_W + TAG_MSB + 1 +: HI_W];
          rr_ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT_RSP: begin
          // A match in the timeout cycle still wins.
          if (match) begin
            rsp_data <= link_rsp;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DELIVER: tag <= tag + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_esp_cmd_arbiter.sv
// Directed bench for esp_cmd_arbiter (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_esp_cmd_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset, enable, link_ready, link_rsp_vld;
  logic [N-1:0]  req_valid, req_ack, rsp_valid;
  logic [N*28-1:0] req_cmd;
  logic [27:0]   rsp_data, issue_cmd, link_rsp;
  logic          rsp_err, issue_valid, busy;
  logic [2:0]    debug_state;

  logic [27:0]   cmds [N];
  logic [7:0]    tag_m;
  int            checks = 0;
  int            errors = 0;

  esp_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .link_ready(link_ready), .issue_cmd(issue_cmd), .issue_valid(issue_valid),
    .link_rsp(link_rsp), .link_rsp_vld(link_rsp_vld),
    .busy(busy), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One matched transaction from IDLE; leaves the DUT back in IDLE.
  task automatic txn(input logic [N-1:0] mask, input int own, input logic [19:0] rsp_hi);
    logic [27:0] c;
    c = cmds[own];
    req_valid = mask;
    tick;
    chk("ack", 32'(req_ack), 32'(1 << own));
    tick;
    chk("issue_vld", 32'(issue_valid), 32'd1);
    chk("issue_cmd", 32'(issue_cmd), 32'({c[27:8], tag_m}));
    tick;
    link_rsp     = {rsp_hi, tag_m};
    link_rsp_vld = 1'b1;
    tick;
    link_rsp_vld = 1'b0;
    chk("rsp_vld", 32'(rsp_valid), 32'(1 << own));
    chk("rsp_data", 32'(rsp_data), 32'({rsp_hi, tag_m}));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    tick;
    chk("idle_busy", 32'(busy), 32'd0);
    tag_m++;
  endtask

  // Transaction that is never answered; junk responses and an optional stall in WAIT_RSP.
  task automatic to_txn(input logic [N-1:0] mask, input int own, input int stall);
    logic [27:0] c;
    int n;
    c = cmds[own];
    req_valid = mask;
    tick;
    chk("to_ack", 32'(req_ack), 32'(1 << own));
    tick;
    chk("to_issue", 32'(issue_cmd), 32'({c[27:8], tag_m}));
    tick;
    n = 0;
    link_rsp     = {20'h8_1234, tag_m + 8'd1};
    link_rsp_vld = 1'b1;
    tick; n++;
    link_rsp     = {20'h0_5678, tag_m};
    tick; n++;
    link_rsp_vld = 1'b0;
    chk("junk_ign", 32'(rsp_valid), 32'd0);
    enable = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      tick; n++;
    end
    enable = 1'b1;
    while (rsp_valid == '0 && n < 40) begin
      tick; n++;
    end
    chk("to_cycles", 32'(n), 32'(TO + stall));
    chk("to_vld", 32'(rsp_valid), 32'(1 << own));
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_data", 32'(rsp_data), 32'd0);
    tick;
    chk("to_idle", 32'(busy), 32'd0);
    tag_m++;
  endtask

  task automatic do_reset;
    req_valid    = '0;
    link_rsp_vld = 1'b0;
    reset        = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tag_m = 8'd0;
  endtask

  initial begin
    cmds[0] = 28'h1230055;
    cmds[1] = 28'h2340011;
    cmds[2] = 28'h3450022;
    cmds[3] = 28'h4560033;
    for (int i = 0; i < N; i++) req_cmd[i*28 +: 28] = cmds[i];
    enable     = 1'b1;
    link_ready = 1'b1;
    link_rsp   = '0;
    do_reset;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(debug_state), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_issue", 32'(issue_cmd), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);

    // 1+2: single transaction, tag 0, response 28'h8ABCD00
    txn(4'b0001, 0, 20'h8ABCD);

    // 3: all requesting -> strict rotation from requester 0
    do_reset;
    for (int k = 0; k < 8; k++) txn(4'b1111, k % 4, 20'h9_0000 + 20'(k));

    // 4: junk responses ignored, then timeout
    to_txn(4'b0010, 1, 0);

    // 5: 256 transactions through tag wrap
    for (int k = 0; k < 256; k++) txn(4'b0100, 2, 20'hA_0000 + 20'(k));
    chk("tag_wrapped", 32'(tag_m), 32'd9);

    // 6: reset during WAIT_RSP discards the transaction
    req_valid = 4'b1000;
    tick; tick; tick;
    chk("w_state", 32'(debug_state), 32'd3);
    reset     = 1'b1;
    req_valid = '0;
    tick;
    reset        = 1'b0;
    link_rsp     = {20'h8_0001, tag_m};
    link_rsp_vld = 1'b1;
    tick;
    chk("ab_rsp", 32'(rsp_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    tick;
    link_rsp_vld = 1'b0;
    chk("ab_rsp2", 32'(rsp_valid), 32'd0);
    tag_m = 8'd0;
    txn(4'b1111, 0, 20'hB_0000);

    // 7: 5-cycle stall in WAIT_RSP delays the timeout by 5
    to_txn(4'b0010, 1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
